// File: rtl/sobel_pkg.sv
// Shared widths, FSM state type and window tap indexing for the Sobel front-end.
package sobel_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_DIM  = 5;
  localparam int unsigned WIN_TAPS = WIN_DIM * WIN_DIM;
  localparam int unsigned WIN_W    = WIN_TAPS * PIX_W;
  localparam int unsigned LB_W     = (WIN_DIM - 1) * PIX_W;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  function automatic int unsigned tap_k(input int unsigned r, input int unsigned c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Single-port line buffer: registered read at addr; we/wdata write back to the
// address read in the previous cycle (read-modify-write pipeline).
module sobel_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr_q;

  always_ff @(posedge clock) begin
    rdata  <= mem[addr];
    addr_q <= addr;
    if (we) begin
      mem[addr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster stream sequencer: line buffer, 5x5 window assembly, window/edge strobes
// with centre coordinates, frame bookkeeping.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned SOBEL_LAT  = 3,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic [WIN_W-1:0] win_out,
  output logic             win_valid,
  output logic             edge_valid,
  output logic [X_W-1:0]   edge_x,
  output logic [Y_W-1:0]   edge_y,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned LB_AW = $clog2(IMG_WIDTH);

  state_e           state, state_nxt;
  logic [X_W-1:0]   col, col_nxt, cur_col;
  logic [Y_W-1:0]   row, row_nxt, cur_row;
  logic             acc, restart, drop, last;

  logic             s1_valid, s1_last;
  logic [PIX_W-1:0] s1_pix;
  logic [X_W-1:0]   s1_col;
  logic [Y_W-1:0]   s1_row;
  logic             interior;

  logic [LB_AW-1:0] lb_addr;
  logic [LB_W-1:0]  lb_wdata, lb_rdata;
  logic [WIN_W-1:0] win_sr, win_shift;
  logic [X_W-1:0]   win_x;
  logic [Y_W-1:0]   win_y;

  logic [SOBEL_LAT-1:0] pv, pv_nxt;
  logic [SOBEL_LAT:0]   pv_ext;
  logic [X_W-1:0]       px [SOBEL_LAT];
  logic [Y_W-1:0]       py [SOBEL_LAT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Pixel acceptance, raster position and frame sequencing.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    cur_col   = col;
    cur_row   = row;
    acc       = 1'b0;
    restart   = 1'b0;
    drop      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (pix_valid) begin
          if (sof) begin
            acc     = 1'b1;
            cur_col = '0;
            cur_row = '0;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (pix_valid) begin
          acc = 1'b1;
          if (sof && (col != '0 || row != '0)) begin
            restart = 1'b1;
            cur_col = '0;
            cur_row = '0;
          end
        end
      end
      default: ;
    endcase
    if (acc) begin
      last = (cur_col == X_W'(IMG_WIDTH - 1)) && (cur_row == Y_W'(IMG_HEIGHT - 1));
      if (cur_col == X_W'(IMG_WIDTH - 1)) begin
        col_nxt = '0;
        row_nxt = cur_row + Y_W'(1);
      end else begin
        col_nxt = cur_col + X_W'(1);
        row_nxt = cur_row;
      end
      if (last) begin
        state_nxt = IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
      end else begin
        state_nxt = ACTIVE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_pix    <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      frame_err <= 1'b0;
    end else begin
      s1_valid  <= acc;
      frame_err <= frame_err | drop | restart;
      if (acc) begin
        s1_pix  <= pix_in;
        s1_col  <= cur_col;
        s1_row  <= cur_row;
        s1_last <= last;
      end
    end
  end

  assign lb_addr  = LB_AW'(cur_col);
  assign lb_wdata = {lb_rdata[LB_W-PIX_W-1:0], s1_pix};
  assign interior = (s1_row >= Y_W'(4)) && (s1_col >= X_W'(4));

  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (LB_W)
  ) u_line_buf (
    .clock (clock),
    .addr  (lb_addr),
    .we    (s1_valid),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  // Shift window left one column; new column is oldest row on top, live pixel at bottom.
  always_comb begin
    win_shift = win_sr;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_shift[tap_k(r, c)*PIX_W +: PIX_W] = win_sr[tap_k(r, c + 1)*PIX_W +: PIX_W];
      end
    end
    for (int r = 0; r < 4; r++) begin
      win_shift[tap_k(r, 4)*PIX_W +: PIX_W] = lb_rdata[(3 - r)*PIX_W +: PIX_W];
    end
    win_shift[tap_k(4, 4)*PIX_W +: PIX_W] = s1_pix;
  end

  assign pv_ext = {pv, win_valid};
  assign pv_nxt = pv_ext[SOBEL_LAT-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_sr     <= '0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      win_valid  <= s1_valid & interior;
      frame_done <= s1_valid & s1_last;
      busy       <= (state_nxt == ACTIVE) | acc | (s1_valid & interior) | (|pv_nxt);
      if (s1_valid) begin
        win_sr <= win_shift;
      end
      if (s1_valid && interior) begin
        win_out <= win_shift;
        win_x   <= s1_col - X_W'(2);
        win_y   <= s1_row - Y_W'(2);
      end
    end
  end

  // Valid/coordinate delay matching the datapath latency; advances every clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < SOBEL_LAT; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      pv    <= pv_nxt;
      px[0] <= win_x;
      py[0] <= win_y;
      for (int i = 1; i < SOBEL_LAT; i++) begin
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  assign edge_valid = pv[SOBEL_LAT-1];
  assign edge_x     = px[SOBEL_LAT-1];
  assign edge_y     = py[SOBEL_LAT-1];

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame with pixel value x+10y.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int LAT = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             sof = 1'b0;
  logic             pix_valid = 1'b0;
  logic [7:0]       pix_in = 8'd0;
  logic [WIN_W-1:0] win_out;
  logic             win_valid, edge_valid, frame_done, frame_err, busy;
  logic [9:0]       edge_x;
  logic [8:0]       edge_y;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int               wv_cyc[$];
  logic [WIN_W-1:0] wv_win[$];
  int               ev_cyc[$], ev_x[$], ev_y[$];
  int               fd_cnt = 0;
  int               fd_cyc = -1;
  int               exp_cyc[$], exp_x[$], exp_y[$];
  int               last_acc = -1;

  sobel_window_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .SOBEL_LAT (LAT),
    .X_W       (10),
    .Y_W       (9)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sof       (sof),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .win_out   (win_out),
    .win_valid (win_valid),
    .edge_valid(edge_valid),
    .edge_x    (edge_x),
    .edge_y    (edge_y),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Record DUT strobes half a cycle after the active edge.
  always @(negedge clock) begin
    if (win_valid) begin
      wv_cyc.push_back(cyc);
      wv_win.push_back(win_out);
    end
    if (edge_valid) begin
      ev_cyc.push_back(cyc);
      ev_x.push_back(int'(edge_x));
      ev_y.push_back(int'(edge_y));
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [WIN_W-1:0] exp_win(input int x, input int y);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w[(5*r+c)*8 +: 8] = 8'((x - 4 + c) + 10 * (y - 4 + r));
      end
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pix_valid = 1'b0;
      sof       = 1'b0;
    end
  endtask

  task automatic send_frame(input int npix, input int gapmode);
    for (int i = 0; i < npix; i++) begin
      int x, y, gap;
      x = i % W;
      y = i / W;
      gap = 0;
      if (gapmode != 0) begin
        gap = i % 2;
        if ($urandom_range(0, 5) == 0) gap += int'($urandom_range(1, 3));
      end
      repeat (gap) begin
        @(negedge clock);
        pix_valid = 1'b0;
        sof       = 1'b0;
      end
      @(negedge clock);
      pix_valid = 1'b1;
      sof       = (i == 0);
      pix_in    = 8'(x + 10 * y);
      if (x >= 4 && y >= 4) begin
        exp_cyc.push_back(cyc + 2);
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
      if (i == W * H - 1) last_acc = cyc;
    end
  endtask

  task automatic clear_all();
    wv_cyc.delete(); wv_win.delete();
    ev_cyc.delete(); ev_x.delete(); ev_y.delete();
    exp_cyc.delete(); exp_x.delete(); exp_y.delete();
    fd_cnt = 0; fd_cyc = -1; last_acc = -1;
  endtask

  task automatic spot_first(input string tag);
    logic [WIN_W-1:0] w;
    if (wv_win.size() > 0 && ev_x.size() > 0) begin
      w = wv_win[0];
      chk({tag, " first z0"}, w[7:0], 0);
      chk({tag, " first z12"}, w[103:96], 22);
      chk({tag, " first z24"}, w[199:192], 44);
      chk({tag, " first cx"}, ev_x[0], 2);
      chk({tag, " first cy"}, ev_y[0], 2);
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " win count"}, wv_cyc.size(), 8);
    for (int i = 0; i < 8 && i < wv_cyc.size(); i++) begin
      chk($sformatf("%s win%0d data", tag, i), wv_win[i], exp_win(exp_x[i], exp_y[i]));
      chk($sformatf("%s win%0d cycle", tag, i), wv_cyc[i], exp_cyc[i]);
    end
    chk({tag, " edge count"}, ev_cyc.size(), 8);
    for (int i = 0; i < 8 && i < ev_cyc.size(); i++) begin
      chk($sformatf("%s edge%0d cycle", tag, i), ev_cyc[i], exp_cyc[i] + LAT);
      chk($sformatf("%s edge%0d x", tag, i), ev_x[i], exp_x[i] - 2);
      chk($sformatf("%s edge%0d y", tag, i), ev_y[i], exp_y[i] - 2);
    end
    chk({tag, " frame_done count"}, fd_cnt, 1);
    chk({tag, " frame_done cycle"}, fd_cyc, last_acc + 2);
    clear_all();
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    chk("rst win_valid", win_valid, 0);
    chk("rst edge_valid", edge_valid, 0);
    chk("rst win_out", win_out, 0);
    chk("rst edge_x", edge_x, 0);
    chk("rst edge_y", edge_y, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // Continuous frame
    send_frame(W * H, 0);
    chk("A busy active", busy, 1);
    idle(12);
    spot_first("A");
    if (wv_win.size() == 8 && ev_x.size() == 8) begin
      chk("A last z24", wv_win[7][199:192], 57);
      chk("A last cx", ev_x[7], 5);
      chk("A last cy", ev_y[7], 3);
    end
    check_frame("A");
    chk("A frame_err", frame_err, 0);
    chk("A busy drained", busy, 0);

    // Pixels without sof after frame end are dropped
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pix_valid = 1'b1;
      sof       = 1'b0;
      pix_in    = 8'd99;
    end
    idle(10);
    chk("drop frame_err", frame_err, 1);
    chk("drop win count", wv_cyc.size(), 0);
    chk("drop edge count", ev_cyc.size(), 0);
    chk("drop busy", busy, 0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    idle(2);
    chk("rst2 frame_err", frame_err, 0);
    clear_all();

    // Gapped frame
    send_frame(W * H, 1);
    idle(12);
    check_frame("B");
    chk("B frame_err", frame_err, 0);

    // sof mid-frame at (3,2): restart there
    send_frame(2 * W + 3, 0);
    send_frame(W * H, 0);
    idle(12);
    chk("restart frame_err", frame_err, 1);
    check_frame("restart");

    // Reset mid-frame at row 3
    send_frame(3 * W + 2, 0);
    @(negedge clock);
    pix_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("midrst win_valid", win_valid, 0);
    chk("midrst edge_valid", edge_valid, 0);
    chk("midrst win_out", win_out, 0);
    chk("midrst frame_err", frame_err, 0);
    chk("midrst busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(6);
    chk("midrst no strobes", wv_cyc.size() + ev_cyc.size(), 0);
    clear_all();
    send_frame(W * H, 0);
    idle(12);
    spot_first("post-reset");
    check_frame("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
